// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dm_arbiter
// Description : Round-robin arbiter sequencing shared single-port DM accesses
//               (issue, read-latency wait, ack) and aggregating core_done.
//               Define DM_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
// Revision    : 1.0  initial release
// ============================================================================
module dm_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int RD_LAT    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        ack,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic [NUM_CORES-1:0]        core_done,
    output logic                        all_done
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = 3;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_WAIT   = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [1:0]           r_state_q, w_state_d;
    logic [NUM_CORES-1:0] r_gnt_q, w_gnt_d;
    logic [NUM_CORES-1:0] r_ack_q, w_ack_d;
    logic [DATA_W-1:0]    r_rdata_q, w_rdata_d;
    logic                 r_mem_en_q, w_mem_en_d;
    logic                 r_mem_we_q, w_mem_we_d;
    logic [ADDR_W-1:0]    r_mem_addr_q, w_mem_addr_d;
    logic [DATA_W-1:0]    r_mem_wdata_q, w_mem_wdata_d;
    logic [CNT_W-1:0]     r_cnt_q, w_cnt_d;
    logic                 r_all_done_q, w_all_done_d;

    logic                 w_found;
    logic [IDX_W-1:0]     w_pick;
    logic [IDX_W-1:0]     w_base;

`ifdef DM_ARB_FIXED_PRIO_EN
    assign w_base = '0;
`else
    logic [IDX_W-1:0] r_rr_ptr_q, w_rr_ptr_d;

    // Pointer moves to the core just past the one that finished.
    always_comb begin
        w_rr_ptr_d = r_rr_ptr_q;
        if (r_state_q == c_DONE) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (r_gnt_q[k]) begin
                    w_rr_ptr_d = (k == NUM_CORES - 1) ? '0 : IDX_W'(k + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr_q <= '0;
        end else begin
            r_rr_ptr_q <= w_rr_ptr_d;
        end
    end

    assign w_base = r_rr_ptr_q;
`endif

    // First requester at or above the base index, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!w_found && req[(int'(w_base) + k) % NUM_CORES]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'((int'(w_base) + k) % NUM_CORES);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= c_IDLE;
            r_gnt_q       <= '0;
            r_ack_q       <= '0;
            r_rdata_q     <= '0;
            r_mem_en_q    <= 1'b0;
            r_mem_we_q    <= 1'b0;
            r_mem_addr_q  <= '0;
            r_mem_wdata_q <= '0;
            r_cnt_q       <= '0;
            r_all_done_q  <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_gnt_q       <= w_gnt_d;
            r_ack_q       <= w_ack_d;
            r_rdata_q     <= w_rdata_d;
            r_mem_en_q    <= w_mem_en_d;
            r_mem_we_q    <= w_mem_we_d;
            r_mem_addr_q  <= w_mem_addr_d;
            r_mem_wdata_q <= w_mem_wdata_d;
            r_cnt_q       <= w_cnt_d;
            r_all_done_q  <= w_all_done_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_IDLE:   if (w_found) w_state_d = c_ACCESS;
            c_ACCESS: w_state_d = (r_mem_we_q || RD_LAT == 1) ? c_DONE : c_WAIT;
            c_WAIT:   if (r_cnt_q == c_CNT_ONE) w_state_d = c_DONE;
            default:  w_state_d = c_IDLE;
        endcase
    end

    always_comb begin
        w_gnt_d       = r_gnt_q;
        w_ack_d       = r_ack_q;
        w_rdata_d     = r_rdata_q;
        w_mem_en_d    = r_mem_en_q;
        w_mem_we_d    = r_mem_we_q;
        w_mem_addr_d  = r_mem_addr_q;
        w_mem_wdata_d = r_mem_wdata_q;
        w_cnt_d       = r_cnt_q;
        w_all_done_d  = &core_done;
        case (r_state_q)
            c_IDLE: begin
                w_gnt_d    = '0;
                w_ack_d    = '0;
                w_mem_en_d = 1'b0;
                w_mem_we_d = 1'b0;
                if (w_found) begin
                    w_gnt_d       = NUM_CORES'(1) << w_pick;
                    w_mem_en_d    = 1'b1;
                    w_mem_we_d    = we[w_pick];
                    w_mem_addr_d  = addr[int'(w_pick)*ADDR_W +: ADDR_W];
                    w_mem_wdata_d = wdata[int'(w_pick)*DATA_W +: DATA_W];
                end
            end
            c_ACCESS: begin
                w_mem_en_d = 1'b0;
                w_mem_we_d = 1'b0;
                if (r_mem_we_q) begin
                    w_ack_d = r_gnt_q;
                end else if (RD_LAT == 1) begin
                    w_ack_d   = r_gnt_q;
                    w_rdata_d = mem_rdata;
                end else begin
                    w_cnt_d = c_CNT_INIT;
                end
            end
            c_WAIT: begin
                if (r_cnt_q == c_CNT_ONE) begin
                    w_ack_d   = r_gnt_q;
                    w_rdata_d = mem_rdata;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt_q - c_CNT_ONE;
                end
            end
            default: begin
                w_gnt_d = '0;
                w_ack_d = '0;
            end
        endcase
    end

    assign gnt       = r_gnt_q;
    assign ack       = r_ack_q;
    assign rdata     = r_rdata_q;
    assign mem_en    = r_mem_en_q;
    assign mem_we    = r_mem_we_q;
    assign mem_addr  = r_mem_addr_q;
    assign mem_wdata = r_mem_wdata_q;
    assign all_done  = r_all_done_q;

endmodule
`default_nettype wire
